// File: rtl/weight_tile_loader.sv
// weight_tile_loader: buffers one NxN weight tile and shifts it into the PE array.
// Build option WEIGHT_TILE_LOADER_DBUF_EN selects ping-pong tile banks.
module weight_tile_loader #(
  parameter int N          = 3,
  parameter int DATA_WIDTH = 8,
  parameter int ACC_WIDTH  = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic [N*DATA_WIDTH-1:0] s_data,
  input  logic                    load_start,
  output logic [N*ACC_WIDTH-1:0]  psum_top,
  output logic                    en_weight_pass,
  output logic [N-1:0]            en_weight_capture,
  output logic                    busy,
  output logic                    load_done
);

  localparam int CW = $clog2(N + 1);
  localparam int KW = (N > 1) ? $clog2(N) : 1;
`ifdef WEIGHT_TILE_LOADER_DBUF_EN
  localparam int NB = 2;
`else
  localparam int NB = 1;
`endif
  localparam int RW = (NB * N > 1) ? $clog2(NB * N) : 1;

  typedef enum logic [1:0] {
    FILL,
    SHIFT,
    DONE
  } state_t;

  state_t state, state_n;

  logic [N*DATA_WIDTH-1:0] rows [NB*N];
  logic [KW-1:0]           k;
  logic                    start_q;
  logic                    take;
  logic                    full_n;
  logic                    go;
  logic [CW-1:0]           fill_cnt;
  logic [RW-1:0]           wr_idx;
  logic [RW-1:0]           rd_idx;

`ifdef WEIGHT_TILE_LOADER_DBUF_EN
  logic          fb;
  logic [CW-1:0] cnt [2];

  // fb is the fill bank; the other bank is the one being shifted
  always_comb begin
    fill_cnt = cnt[fb];
    wr_idx   = (fb ? RW'(N) : RW'(0)) + RW'(cnt[fb]);
    rd_idx   = (fb ? RW'(0) : RW'(N))
             + RW'(N - 1) - RW'(k);
    s_ready  = rst_n && (cnt[fb] < CW'(N));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt[0] <= '0;
      cnt[1] <= '0;
      fb     <= 1'b0;
    end else begin
      if (take)
        cnt[fb] <= cnt[fb] + CW'(1);
      if (state == DONE)
        cnt[!fb] <= '0;
      if (go && state != SHIFT)
        fb <= !fb;
    end
  end
`else
  logic [CW-1:0] cnt;

  always_comb begin
    fill_cnt = cnt;
    wr_idx   = RW'(cnt);
    rd_idx   = RW'(N - 1) - RW'(k);
    s_ready  = rst_n && (state == FILL)
            && (cnt < CW'(N));
  end

  always_ff @(posedge clk) begin
    if (!rst_n)
      cnt <= '0;
    else if (state == DONE)
      cnt <= '0;
    else if (take)
      cnt <= cnt + CW'(1);
  end
`endif

  assign take   = s_valid && s_ready;
  // count as it will be after this edge, so a start with the last beat costs no cycle
  assign full_n = (fill_cnt == CW'(N))
               || (take && fill_cnt == CW'(N - 1));
  assign go     = full_n && (load_start || start_q);

  always_comb begin
    state_n = state;
    unique case (state)
      FILL:    if (go) state_n = SHIFT;
      SHIFT:   if (k == KW'(N - 1)) state_n = DONE;
`ifdef WEIGHT_TILE_LOADER_DBUF_EN
      DONE:    state_n = go ? SHIFT : FILL;
`else
      DONE:    state_n = FILL;
`endif
      default: state_n = FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= FILL;
      k       <= '0;
      start_q <= 1'b0;
    end else begin
      state <= state_n;
      if (state == SHIFT && k != KW'(N - 1))
        k <= k + KW'(1);
      else
        k <= '0;
      if (state != SHIFT && state_n == SHIFT)
        start_q <= 1'b0;
      else if (state != SHIFT)
        start_q <= start_q | load_start;
    end
  end

  always_ff @(posedge clk) begin
    if (take)
      rows[wr_idx] <= s_data;
  end

  // last row leaves first; row r reaches its PEs after r more stages
  always_comb begin
    psum_top          = '0;
    en_weight_pass    = 1'b0;
    en_weight_capture = '0;
    busy              = 1'b0;
    load_done         = 1'b0;
    if (state == SHIFT) begin
      for (int c = 0; c < N; c++)
        psum_top[c*ACC_WIDTH +: ACC_WIDTH] =
          ACC_WIDTH'(rows[rd_idx][c*DATA_WIDTH +: DATA_WIDTH]);
      en_weight_pass = 1'b1;
      busy           = 1'b1;
      if (k == KW'(N - 1))
        en_weight_capture = '1;
    end
    if (state == DONE)
      load_done = 1'b1;
  end

endmodule

// File: doc/weight_tile_loader.md
Name: weight_tile_loader

Overview:
- Upstream feeder for the N x N systolic PE array: buffers one NxN weight tile from a valid/ready stream, then injects it into the top of the PE columns through the psum path.
- Drives the array's weight-pass and per-row weight-capture controls so every PE latches its own weight, and handshakes with the matmul controller through start/busy/done.

Parameters:
- N, 3, array dimension (rows = columns = N)
- DATA_WIDTH, 8, weight element width
- ACC_WIDTH, 32, psum path width (must be >= DATA_WIDTH)

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  reset, synchronous, active-low
- s_valid  in  1  weight row beat valid
- s_ready  out  1  loader can accept a row beat
- s_data  in  N*DATA_WIDTH  one weight row; element c at bits [c*DATA_WIDTH +: DATA_WIDTH] is for PE(row, c)
- load_start  in  1  controller request to push the buffered tile into the array
- psum_top  out  N*ACC_WIDTH  column-top psum_in for array row 0; column c at [c*ACC_WIDTH +: ACC_WIDTH]
- en_weight_pass  out  1  array-wide weight pass enable
- en_weight_capture  out  N  per-row capture enable; bit r goes to all PEs of row r
- busy  out  1  shift sequence in progress
- load_done  out  1  one-cycle pulse when the tile is latched in the array

Behaviour:
- Clock: single clock clk. Reset: rst_n is synchronous and active-low (sampled on the clk rising edge).
- Reset values: s_ready=0 while rst_n=0; after reset, s_ready=1. psum_top=0, en_weight_pass=0, en_weight_capture=0, busy=0, load_done=0. Row count=0, start latch clear, state=FILL. Buffer contents are don't-care.
- Row intake: beats are transferred on s_valid&&s_ready. Rows arrive in order row 0..N-1 and are stored at index = row count, which then increments. s_ready = (state==FILL && count<N). Once count==N, s_ready=0 until the tile has been shifted out.
- States: FILL, SHIFT, DONE.
  - FILL: accepts rows. load_start is latched (sticky) in every state except SHIFT. Transition to SHIFT when count==N and (load_start || latch); the latch clears on entry.
  - If load_start arrives in the same cycle as the Nth beat, SHIFT is entered on the next edge with no lost cycle.
  - load_start during SHIFT is ignored.
- SHIFT: lasts exactly N cycles, k=0..N-1, all outputs registered.
  - In cycle k: psum_top column c = zero-extended buffer[N-1-k][c], en_weight_pass=1, busy=1.
  - en_weight_capture = all-ones in cycle k=N-1 only, 0 otherwise. Because each PE row adds one register stage, row r sees its weight at psum_in in cycle (N-1-r)+r = N-1, so all rows capture on the same edge.
- DONE: lasts one cycle.
  - load_done=1, psum_top=0, en_weight_pass=0, busy=0. Count is cleared.
  - Next state is FILL with s_ready=1.
- Latency: load_start sampled at edge E with a full buffer -> SHIFT k=0 in the cycle after E -> capture in cycle N after E -> load_done in cycle N+1 after E.
- Outside SHIFT, psum_top=0 and en_weight_pass=0, so the array computes undisturbed.
- Width rule: upper ACC_WIDTH-DATA_WIDTH bits of each psum_top column are always 0. Weight bits are passed raw; signedness is interpreted by the PE.
- Reset mid-SHIFT: all outputs return to their reset values on the reset edge. The partial tile is discarded, the start latch clears, and no capture or done pulse occurs.
- s_valid with s_ready=0: no transfer, data ignored, no error.

Optional Feature:
- WEIGHT_TILE_LOADER_DBUF_EN
- Defined:
  - Two tile banks in ping-pong. FILL into the idle bank continues during SHIFT and DONE.
  - s_ready = (idle-bank count<N).
  - At SHIFT entry the full bank becomes the shift bank and the other becomes the fill bank.
  - A latched start with the other bank full re-enters SHIFT directly from DONE, giving back-to-back tiles with a 1-cycle gap.
- Undefined: single bank exactly as described in Behaviour.

Test Plan:
1. N=3; push rows {1,2,3},{4,5,6},{7,8,9}, then pulse load_start. Required: psum_top = {7,8,9} in k=0, {4,5,6} in k=1, {1,2,3} in k=2. en_weight_capture=3'b111 only in k=2. load_done in the next cycle. An attached 3x3 PE array must hold weight(r,c)=3r+c+1.
2. load_start pulsed after 1 row. Rows 2 and 3 are pushed later. Required: SHIFT starts the cycle after the 3rd beat (latched start); no output activity before that.
3. 3rd beat and load_start in the same cycle. Required: k=0 in the next cycle; s_ready=0 from that cycle until DONE.
4. s_valid held high with data 0xFF while the buffer is full or SHIFT is active (single bank). Required: s_ready=0 and no buffer overwrite; the tile from test 1 is unchanged.
5. rst_n=0 in SHIFT k=1. Required: all outputs 0 on the next edge, no capture or load_done pulse, s_ready=1 after release, and a fresh tile loads correctly.
6. With WEIGHT_TILE_LOADER_DBUF_EN: stream 6 rows continuously and hold load_start high. Required: tile A shifts while tile B fills, tile B's SHIFT k=0 begins 1 cycle after A's load_done, and the values are correct for both tiles.
